uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_transmiter instance between NUM_REQ byte requesters (frame ACK/NACK
//  responder, status reporter, debug echo). Round-robin grant; drives start_strobe/data,
//  tracks the busy handshake and returns per-requester accept and complete pulses.
// PARAMETERS
//  NUM_REQ         4       number of requesters, 2..8
//  TIMEOUT_CYCLES  200000  watchdog limit per wait state (UART_TX_ARB_TIMEOUT_EN only)
// PORTS
//  clk        in   1          system clock
//  rst        in   1          synchronous reset, active-high
//  req        in   NUM_REQ    level request; held with req_data stable until ack
//  req_data   in   8*NUM_REQ  byte of requester i at [8*i+7:8*i]
//  ack        out  NUM_REQ    1-cycle pulse: byte of requester i latched
//  done       out  NUM_REQ    1-cycle pulse: byte of requester i fully transmitted
//  err        out  NUM_REQ    1-cycle pulse: watchdog abort (0 when macro off)
//  tx_start   out  1          to uart_transmiter start_strobe, 1-cycle pulse
//  tx_data    out  8          to uart_transmiter data, registered, held until next grant
//  tx_busy    in   1          from uart_transmiter busy
//  grant_id   out  3          index of current/last granted requester
//  active     out  1          high in every state except IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, ack/done/err=0, tx_start=0, tx_data=0, grant_id=0, active=0,
//    rr pointer=0, busy-edge register=0. Reset mid-transfer does not abort the transmitter;
//    arbiter simply waits in IDLE until tx_busy=0.
//  - IDLE: if |req and tx_busy==0: pick first requester at/after rr pointer (wrapping);
//    at that edge latch tx_data, grant_id, ack[g]=1 (next cycle), state->LAUNCH,
//    rr pointer<=g+1 mod NUM_REQ. Else stay.
//  - LAUNCH (1 cycle): tx_start=1; ->WAIT_BUSY.
//  - WAIT_BUSY: on tx_busy==1 ->WAIT_DONE.
//  - WAIT_DONE: on tx_busy falling edge (registered prev=1, now=0): done[grant_id]=1
//    next cycle, ->IDLE.
//  - Latency: req seen in IDLE at edge k -> ack and tx_start high during cycle k+1.
//    Back-to-back: next grant evaluated the cycle after done; no bubble beyond that.
//  - Simultaneous requests: strictly round-robin from pointer; a requester is never
//    granted twice while another has held req throughout.
//  - req dropped before ack: withdrawal allowed, not granted. req held after ack: treated
//    as a new request (requester must drop req the cycle ack is seen to send one byte).
//  - req_data sampled only on the grant edge; later changes ignored.
//  - At most one bit set in ack, done, err at any cycle; ack and done never for the
//    same byte in one cycle.
//  - grant_id width fixed 3; upper bits 0 when NUM_REQ<8.
// CONFIGURATION
//  UART_TX_ARB_TIMEOUT_EN defined: 32-bit counter cleared on entry to WAIT_BUSY and
//    WAIT_DONE; if it reaches TIMEOUT_CYCLES in either state, err[grant_id]=1 next cycle,
//    no done pulse, ->IDLE (next grant still waits for tx_busy==0).
//  Not defined: no counter; err tied to 0; WAIT states wait indefinitely.
// TESTING
//  1 reset: rst=1 3 cycles with req=4'hF -> ack/done/err/tx_start=0, active=0 throughout.
//  2 single: req[2]=1 data 8'hFF, model busy high 2 cycles after start for 100 cycles
//    -> ack[2] with tx_start same cycle, tx_data=8'hFF, done[2] 1 cycle after busy falls.
//  3 contention: req=4'b1011 held, data 8'h11/8'h22/--/8'h44 -> grant order 0,1,3,0,...;
//    tx_data sequence 11,22,44,11; exactly one done per ack.
//  4 withdraw + busy-at-idle: tx_busy=1 externally, req[1] pulsed 5 cycles then dropped
//    -> no ack, no tx_start; req[1] raised after busy low -> ack[1] next cycle.
//  5 reset mid-transfer: rst in WAIT_DONE -> outputs zero, no done; new req[0] granted
//    only after tx_busy falls.
//  6 timeout (macro on, TIMEOUT_CYCLES=50): busy never rises after tx_start -> err[g]
//    pulse 51 cycles after entering WAIT_BUSY, no done, state IDLE; macro off -> stays.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares a single UART transmitter between NUM_REQ byte requesters. A
// round-robin pointer selects the next requester whenever the arbiter is idle
// and the transmitter reports not busy. The granted byte is registered onto
// tx_data, tx_start pulses for one cycle, and the arbiter then follows the
// transmitter's busy handshake (rise, then fall) before returning to idle.
//
// Optional feature (macro UART_TX_ARB_TIMEOUT_EN):
//   When defined, a watchdog counter guards both wait states. If the
//   transmitter never raises busy, or never drops it, for TIMEOUT_CYCLES
//   cycles, the transfer is abandoned with an err pulse instead of done.
//   When undefined, err is always 0 and the wait states wait indefinitely.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous reset, active-high
//   req       in   [NUM_REQ]   level request per requester
//   req_data  in   [8*NUM_REQ] byte of requester i at [8*i+7:8*i]
//   ack       out  [NUM_REQ]   1-cycle pulse, byte of requester i latched
//   done      out  [NUM_REQ]   1-cycle pulse, byte of requester i sent
//   err       out  [NUM_REQ]   1-cycle pulse, watchdog abort
//   tx_start  out  start strobe to the transmitter
//   tx_data   out  [8] byte to the transmitter, held until the next grant
//   tx_busy   in   busy flag from the transmitter
//   grant_id  out  [3] index of the current / last granted requester
//   active    out  high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   done,
  output logic [NUM_REQ-1:0]   err,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [2:0]           grant_id,
  output logic                 active
);

  // Elaboration-time sanity check on the configuration.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t             state_reg, state_next;
  logic [2:0]         rr_ptr_reg, rr_ptr_next;
  logic [7:0]         tx_data_reg, tx_data_next;
  logic [2:0]         grant_id_reg, grant_id_next;
  logic [NUM_REQ-1:0] ack_reg, ack_next;
  logic [NUM_REQ-1:0] done_reg, done_next;
  logic [NUM_REQ-1:0] err_reg, err_next;
  logic               busy_prev_reg;

  logic               pick_valid;
  logic [2:0]         pick_idx;
  logic [NUM_REQ-1:0] pick_hot;
  logic [NUM_REQ-1:0] grant_hot;
  logic [7:0]         pick_byte;
  logic [7:0]         req_byte [NUM_REQ];
  logic               timeout_hit;

  // Per-requester byte view plus one-hot decodes of the candidate and the
  // current grant (used for ack and for done/err respectively).
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_byte[gi]  = req_data[8*gi +: 8];
    assign pick_hot[gi]  = (pick_idx == 3'(gi));
    assign grant_hot[gi] = (grant_id_reg == 3'(gi));
  end

  // Round-robin search: scan offsets from the highest down so that the
  // lowest offset from the pointer (the first requester at/after it) wins.
  always_comb begin
    logic [3:0] cand;
    cand       = '0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = {1'b0, rr_ptr_reg} + 4'(off);
      if (cand >= 4'(NUM_REQ)) begin
        cand = cand - 4'(NUM_REQ);
      end
      if ((req & (ONE_HOT0 << cand)) != '0) begin
        pick_valid = 1'b1;
        pick_idx   = cand[2:0];
      end
    end
  end

  // AND-OR mux of the candidate's byte.
  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_byte = pick_byte | (req_byte[i] & {8{pick_hot[i]}});
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [31:0] timer_reg;

  // Cleared on every state change, so it restarts on entry to each wait
  // state; only counts while waiting on the transmitter.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_reg <= '0;
    end else if (state_next != state_reg) begin
      timer_reg <= '0;
    end else if (state_reg == ST_WAIT_BUSY || state_reg == ST_WAIT_DONE) begin
      timer_reg <= timer_reg + 32'd1;
    end
  end

  assign timeout_hit = (timer_reg == 32'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      rr_ptr_reg    <= '0;
      tx_data_reg   <= '0;
      grant_id_reg  <= '0;
      ack_reg       <= '0;
      done_reg      <= '0;
      err_reg       <= '0;
      busy_prev_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      tx_data_reg   <= tx_data_next;
      grant_id_reg  <= grant_id_next;
      ack_reg       <= ack_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      busy_prev_reg <= tx_busy;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    tx_data_next  = tx_data_reg;
    grant_id_next = grant_id_reg;
    ack_next      = '0;
    done_next     = '0;
    err_next      = '0;
    case (state_reg)
      ST_IDLE: begin
        // A transmitter still busy from before a reset (or from an aborted
        // transfer) blocks new grants until it goes idle.
        if (pick_valid && !tx_busy) begin
          state_next    = ST_LAUNCH;
          tx_data_next  = pick_byte;
          grant_id_next = pick_idx;
          ack_next      = pick_hot;
          rr_ptr_next   = (pick_idx == 3'(NUM_REQ - 1)) ? 3'd0 : pick_idx + 3'd1;
        end
      end
      ST_LAUNCH: begin
        state_next = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = ST_WAIT_DONE;
        end else if (timeout_hit) begin
          err_next   = grant_hot;
          state_next = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (busy_prev_reg && !tx_busy) begin
          done_next  = grant_hot;
          state_next = ST_IDLE;
        end else if (timeout_hit) begin
          err_next   = grant_hot;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    tx_start = (state_reg == ST_LAUNCH);
    active   = (state_reg != ST_IDLE);
  end

  assign ack      = ack_reg;
  assign done     = done_reg;
  assign err      = err_reg;
  assign tx_data  = tx_data_reg;
  assign grant_id = grant_id_reg;

endmodule
